// File: rtl/down_timer_pkg.sv
// Shared types and constants for the loadable down-counting timer.
package down_timer_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } timer_state_t;

    localparam logic MODE_ONESHOT = 1'b0;
    localparam logic MODE_AUTO    = 1'b1;

endpackage

// File: rtl/down_count_core.sv
// WIDTH-bit count register with clear, load and decrement, plus an is_one flag
// that lets the controller see the terminal step one cycle ahead.
module down_count_core
    import down_timer_pkg::*;
#(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clr,
    input  logic             load,
    input  logic             dec,
    input  logic [WIDTH-1:0] load_value,
    output logic [WIDTH-1:0] count,
    output logic             is_one
);

    localparam logic [WIDTH-1:0] ZERO_C = {WIDTH{1'b0}};
    localparam logic [WIDTH-1:0] ONE_C  = {{(WIDTH-1){1'b0}}, 1'b1};

    logic [WIDTH-1:0] count_r;

    // Count register: clear beats load beats decrement; never steps below zero.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            count_r <= ZERO_C;
        end else if (clr) begin
            count_r <= ZERO_C;
        end else if (load) begin
            count_r <= load_value;
        end else if (dec && (count_r != ZERO_C)) begin
            count_r <= count_r - ONE_C;
        end else begin
            count_r <= count_r;
        end
    end

    assign count  = count_r;
    assign is_one = (count_r == ONE_C);

endmodule

// File: rtl/down_count_timer.sv
// Loadable down-counting timer with one-shot and auto-reload modes,
// a valid/ready load handshake and a registered terminal-count pulse.
module down_count_timer
    import down_timer_pkg::*;
#(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load_valid,
    output logic             load_ready,
    input  logic [WIDTH-1:0] load_value,
    input  logic             load_auto,
    input  logic             en,
    input  logic             abort,
    output logic [WIDTH-1:0] count,
    output logic             busy,
    output logic             tc
);

    localparam logic [WIDTH-1:0] ZERO_C = {WIDTH{1'b0}};

    timer_state_t     state_r;
    timer_state_t     state_next_s;
    logic [WIDTH-1:0] reload_r;
    logic             auto_r;
    logic             tc_r;
    logic             busy_r;
    logic             load_ready_r;

    logic             load_acc_s;
    logic             core_clr_s;
    logic             core_load_s;
    logic             core_dec_s;
    logic [WIDTH-1:0] core_value_s;
    logic             tc_next_s;
    logic             is_one_s;
    logic [WIDTH-1:0] count_s;

    // abort wins over a simultaneous load, so it also masks the accept.
    assign load_acc_s = load_valid && load_ready_r && !abort;

    down_count_core #(
        .WIDTH (WIDTH)
    ) u_core (
        .clk        (clk),
        .rst        (rst),
        .clr        (core_clr_s),
        .load       (core_load_s),
        .dec        (core_dec_s),
        .load_value (core_value_s),
        .count      (count_s),
        .is_one     (is_one_s)
    );

    // State register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_next_s;
        end
    end

    // Next-state logic: abort > load accept > enabled countdown.
    always_comb begin
        state_next_s = state_r;
        if (abort) begin
            state_next_s = IDLE;
        end else if (load_acc_s) begin
            state_next_s = (load_value == ZERO_C) ? DONE : RUN;
        end else begin
            case (state_r)
                RUN: begin
                    if (en && is_one_s && (auto_r != MODE_AUTO)) begin
                        state_next_s = DONE;
                    end else begin
                        state_next_s = RUN;
                    end
                end
                IDLE:    state_next_s = IDLE;
                DONE:    state_next_s = DONE;
                default: state_next_s = IDLE;
            endcase
        end
    end

    // Output/datapath control: what the core does and whether tc fires next cycle.
    always_comb begin
        core_clr_s   = 1'b0;
        core_load_s  = 1'b0;
        core_dec_s   = 1'b0;
        core_value_s = load_value;
        tc_next_s    = 1'b0;
        if (abort) begin
            core_clr_s = 1'b1;
        end else if (load_acc_s) begin
            core_load_s = 1'b1;
            tc_next_s   = (load_value == ZERO_C);
        end else if ((state_r == RUN) && en) begin
            if (is_one_s) begin
                tc_next_s = 1'b1;
                if (auto_r == MODE_AUTO) begin
                    core_load_s  = 1'b1;
                    core_value_s = reload_r;
                end else begin
                    core_dec_s = 1'b1;
                end
            end else begin
                core_dec_s = 1'b1;
            end
        end else begin
            core_dec_s = 1'b0;
        end
    end

    // Reload value and mode are captured only on an accepted load.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            reload_r <= ZERO_C;
            auto_r   <= MODE_ONESHOT;
        end else if (load_acc_s) begin
            reload_r <= load_value;
            auto_r   <= load_auto;
        end else begin
            reload_r <= reload_r;
            auto_r   <= auto_r;
        end
    end

    // Registered status outputs, decoded from the next state so they align with it.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            tc_r         <= 1'b0;
            busy_r       <= 1'b0;
            load_ready_r <= 1'b1;
        end else begin
            tc_r         <= tc_next_s;
            busy_r       <= (state_next_s == RUN);
            load_ready_r <= (state_next_s != RUN);
        end
    end

    assign count      = count_s;
    assign tc         = tc_r;
    assign busy       = busy_r;
    assign load_ready = load_ready_r;

endmodule

// File: tb/tb_down_count_timer.sv
// Directed self-checking bench for down_count_timer; each observation packs
// {count, tc, busy, load_ready} and is compared against a hand-computed value.
module tb_down_count_timer;

    logic       clk;
    logic       rst;
    logic       load_valid;
    logic       load_ready;
    logic [3:0] load_value;
    logic       load_auto;
    logic       en;
    logic       abort;
    logic [3:0] count;
    logic       busy;
    logic       tc;

    int n_cmp;
    int n_err;

    down_count_timer #(.WIDTH(4)) dut (
        .clk        (clk),
        .rst        (rst),
        .load_valid (load_valid),
        .load_ready (load_ready),
        .load_value (load_value),
        .load_auto  (load_auto),
        .en         (en),
        .abort      (abort),
        .count      (count),
        .busy       (busy),
        .tc         (tc)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1; load_valid = 1'b0; load_value = 4'd0; load_auto = 1'b0;
        en = 1'b0; abort = 1'b0;
        #2 rst = 1'b0;
        #1;
        n_cmp++;
        if (count !== 4'd0) begin n_err++; $display("FAIL reset_count: got %0d want 0", count); end
        n_cmp++;
        if (busy !== 1'b0) begin n_err++; $display("FAIL reset_busy: got %b want 0", busy); end
        n_cmp++;
        if (tc !== 1'b0) begin n_err++; $display("FAIL reset_tc: got %b want 0", tc); end
        n_cmp++;
        if (load_ready !== 1'b1) begin n_err++; $display("FAIL reset_ready: got %b want 1", load_ready); end
        load_valid = 1'b1; load_value = 4'd5; en = 1'b1;
        tick();
        n_cmp++;
        if ({count, tc, busy, load_ready} !== {4'd0, 1'b0, 1'b0, 1'b1}) begin
            n_err++; $display("FAIL reset_hold: got %b want %b", {count, tc, busy, load_ready}, {4'd0, 3'b001});
        end
        #2 rst = 1'b1;
        load_valid = 1'b0; en = 1'b0;
    endtask

    task automatic test_oneshot();
        logic [6:0] exp;
        load_valid = 1'b1; load_value = 4'd5; load_auto = 1'b0; en = 1'b1;
        tick();
        load_valid = 1'b0;
        n_cmp++;
        if ({count, tc, busy, load_ready} !== {4'd5, 3'b010}) begin
            n_err++; $display("FAIL oneshot_accept: got %b want %b", {count, tc, busy, load_ready}, {4'd5, 3'b010});
        end
        for (int i = 4; i >= 0; i--) begin
            tick();
            exp = (i == 0) ? {4'd0, 3'b101} : {4'(i), 3'b010};
            n_cmp++;
            if ({count, tc, busy, load_ready} !== exp) begin
                n_err++; $display("FAIL oneshot_step%0d: got %b want %b", i, {count, tc, busy, load_ready}, exp);
            end
        end
        tick();
        n_cmp++;
        if ({count, tc, busy, load_ready} !== {4'd0, 3'b001}) begin
            n_err++; $display("FAIL oneshot_done: got %b want %b", {count, tc, busy, load_ready}, {4'd0, 3'b001});
        end
    endtask

    // Starts from DONE, so this also covers restart-from-DONE.
    task automatic test_auto_reload();
        logic [3:0] seq [10];
        logic [6:0] exp;
        seq = '{4'd2, 4'd1, 4'd3, 4'd2, 4'd1, 4'd3, 4'd2, 4'd1, 4'd3, 4'd2};
        load_valid = 1'b1; load_value = 4'd3; load_auto = 1'b1; en = 1'b1;
        tick();
        load_valid = 1'b0;
        n_cmp++;
        if ({count, tc, busy, load_ready} !== {4'd3, 3'b010}) begin
            n_err++; $display("FAIL auto_accept: got %b want %b", {count, tc, busy, load_ready}, {4'd3, 3'b010});
        end
        for (int i = 0; i < 10; i++) begin
            tick();
            exp = {seq[i], (seq[i] == 4'd3), 2'b10};
            n_cmp++;
            if ({count, tc, busy, load_ready} !== exp) begin
                n_err++; $display("FAIL auto_step%0d: got %b want %b", i, {count, tc, busy, load_ready}, exp);
            end
        end
        abort = 1'b1;
        tick();
        abort = 1'b0;
        n_cmp++;
        if ({count, tc, busy, load_ready} !== {4'd0, 3'b001}) begin
            n_err++; $display("FAIL auto_abort: got %b want %b", {count, tc, busy, load_ready}, {4'd0, 3'b001});
        end
    endtask

    task automatic test_enable_gating();
        logic       ens [6];
        logic [3:0] cnt [6];
        logic [6:0] exp;
        ens = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1};
        cnt = '{4'd3, 4'd3, 4'd3, 4'd2, 4'd1, 4'd0};
        load_valid = 1'b1; load_value = 4'd4; load_auto = 1'b0; en = 1'b1;
        tick();
        load_valid = 1'b0;
        n_cmp++;
        if ({count, tc, busy, load_ready} !== {4'd4, 3'b010}) begin
            n_err++; $display("FAIL enable_accept: got %b want %b", {count, tc, busy, load_ready}, {4'd4, 3'b010});
        end
        for (int i = 0; i < 6; i++) begin
            en = ens[i];
            tick();
            exp = (cnt[i] == 4'd0) ? {4'd0, 3'b101} : {cnt[i], 3'b010};
            n_cmp++;
            if ({count, tc, busy, load_ready} !== exp) begin
                n_err++; $display("FAIL enable_step%0d: got %b want %b", i, {count, tc, busy, load_ready}, exp);
            end
        end
    endtask

    task automatic test_load_zero();
        load_valid = 1'b1; load_value = 4'd0; load_auto = 1'b1; en = 1'b1;
        tick();
        load_valid = 1'b0;
        n_cmp++;
        if ({count, tc, busy, load_ready} !== {4'd0, 3'b101}) begin
            n_err++; $display("FAIL zero_pulse: got %b want %b", {count, tc, busy, load_ready}, {4'd0, 3'b101});
        end
        tick();
        n_cmp++;
        if ({count, tc, busy, load_ready} !== {4'd0, 3'b001}) begin
            n_err++; $display("FAIL zero_after: got %b want %b", {count, tc, busy, load_ready}, {4'd0, 3'b001});
        end
    endtask

    task automatic test_all_ones();
        logic [6:0] exp;
        load_valid = 1'b1; load_value = 4'd15; load_auto = 1'b0; en = 1'b1;
        tick();
        load_valid = 1'b0;
        n_cmp++;
        if ({count, tc, busy, load_ready} !== {4'd15, 3'b010}) begin
            n_err++; $display("FAIL ones_accept: got %b want %b", {count, tc, busy, load_ready}, {4'd15, 3'b010});
        end
        for (int i = 14; i >= 0; i--) begin
            tick();
            exp = (i == 0) ? {4'd0, 3'b101} : {4'(i), 3'b010};
            n_cmp++;
            if ({count, tc, busy, load_ready} !== exp) begin
                n_err++; $display("FAIL ones_step%0d: got %b want %b", i, {count, tc, busy, load_ready}, exp);
            end
        end
        tick();
        n_cmp++;
        if ({count, tc, busy, load_ready} !== {4'd0, 3'b001}) begin
            n_err++; $display("FAIL ones_nowrap: got %b want %b", {count, tc, busy, load_ready}, {4'd0, 3'b001});
        end
    endtask

    task automatic test_reload_one();
        load_valid = 1'b1; load_value = 4'd1; load_auto = 1'b1; en = 1'b1;
        tick();
        load_valid = 1'b0;
        n_cmp++;
        if ({count, tc, busy, load_ready} !== {4'd1, 3'b010}) begin
            n_err++; $display("FAIL one_accept: got %b want %b", {count, tc, busy, load_ready}, {4'd1, 3'b010});
        end
        for (int i = 0; i < 4; i++) begin
            tick();
            n_cmp++;
            if ({count, tc, busy, load_ready} !== {4'd1, 3'b110}) begin
                n_err++; $display("FAIL one_step%0d: got %b want %b", i, {count, tc, busy, load_ready}, {4'd1, 3'b110});
            end
        end
        en = 1'b0;
        tick();
        n_cmp++;
        if ({count, tc, busy, load_ready} !== {4'd1, 3'b010}) begin
            n_err++; $display("FAIL one_hold: got %b want %b", {count, tc, busy, load_ready}, {4'd1, 3'b010});
        end
        abort = 1'b1;
        tick();
        abort = 1'b0;
        n_cmp++;
        if ({count, tc, busy, load_ready} !== {4'd0, 3'b001}) begin
            n_err++; $display("FAIL one_abort: got %b want %b", {count, tc, busy, load_ready}, {4'd0, 3'b001});
        end
    endtask

    task automatic test_simultaneous();
        load_valid = 1'b1; load_value = 4'd7; load_auto = 1'b0; en = 1'b1; abort = 1'b1;
        tick();
        abort = 1'b0;
        n_cmp++;
        if ({count, tc, busy, load_ready} !== {4'd0, 3'b001}) begin
            n_err++; $display("FAIL sim_abort_load: got %b want %b", {count, tc, busy, load_ready}, {4'd0, 3'b001});
        end
        load_value = 4'd6;
        tick();
        n_cmp++;
        if ({count, tc, busy, load_ready} !== {4'd6, 3'b010}) begin
            n_err++; $display("FAIL sim_accept: got %b want %b", {count, tc, busy, load_ready}, {4'd6, 3'b010});
        end
        load_value = 4'd2;
        tick();
        n_cmp++;
        if ({count, tc, busy, load_ready} !== {4'd5, 3'b010}) begin
            n_err++; $display("FAIL sim_run_load1: got %b want %b", {count, tc, busy, load_ready}, {4'd5, 3'b010});
        end
        tick();
        n_cmp++;
        if ({count, tc, busy, load_ready} !== {4'd4, 3'b010}) begin
            n_err++; $display("FAIL sim_run_load2: got %b want %b", {count, tc, busy, load_ready}, {4'd4, 3'b010});
        end
        abort = 1'b1;
        tick();
        abort = 1'b0; load_valid = 1'b0;
        n_cmp++;
        if ({count, tc, busy, load_ready} !== {4'd0, 3'b001}) begin
            n_err++; $display("FAIL sim_run_abort: got %b want %b", {count, tc, busy, load_ready}, {4'd0, 3'b001});
        end
    endtask

    task automatic test_async_reset();
        load_valid = 1'b1; load_value = 4'd9; load_auto = 1'b0; en = 1'b1;
        tick();
        load_valid = 1'b0;
        tick(); tick(); tick();
        n_cmp++;
        if ({count, tc, busy, load_ready} !== {4'd6, 3'b010}) begin
            n_err++; $display("FAIL areset_pre: got %b want %b", {count, tc, busy, load_ready}, {4'd6, 3'b010});
        end
        #2 rst = 1'b0;
        #1;
        n_cmp++;
        if ({count, tc, busy, load_ready} !== {4'd0, 3'b001}) begin
            n_err++; $display("FAIL areset_immediate: got %b want %b", {count, tc, busy, load_ready}, {4'd0, 3'b001});
        end
        @(posedge clk);
        #3 rst = 1'b1;
        for (int i = 0; i < 2; i++) begin
            tick();
            n_cmp++;
            if ({count, tc, busy, load_ready} !== {4'd0, 3'b001}) begin
                n_err++; $display("FAIL areset_after%0d: got %b want %b", i, {count, tc, busy, load_ready}, {4'd0, 3'b001});
            end
        end
        en = 1'b0;
    endtask

    initial begin
        n_cmp = 0;
        n_err = 0;
        test_reset();
        test_oneshot();
        test_auto_reload();
        test_enable_gating();
        test_load_zero();
        test_all_ones();
        test_reload_one();
        test_simultaneous();
        test_async_reset();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/down_count_timer.md
Name: down_count_timer

Overview:
- Loadable, parameterised down-counting timer.
- Counterpart to the team's free-running up counter: that block counts up from 0 and wraps; this block is loaded with a value, counts down to zero and reports terminal count.
- Used as a programmable delay or period generator by control logic.
- Operates in two modes: one-shot, or auto-reload for periodic ticks.

Parameters:
- WIDTH, 4, bit width of load value and count.

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  asynchronous active-low reset.
- load_valid  input  1  load request; qualifies load_value and load_auto.
- load_ready  output  1  timer can accept a load this cycle.
- load_value  input  WIDTH  start/reload value.
- load_auto  input  1  mode select: 1 = auto-reload, 0 = one-shot.
- en  input  1  count enable; when low, the count holds.
- abort  input  1  synchronous cancel.
- count  output  WIDTH  current count (registered).
- busy  output  1  high in RUN state.
- tc  output  1  terminal-count pulse, registered, one cycle wide.

Behaviour:
- Reset is asynchronous active-low. While rst = 0:
  - state = IDLE, count = 0, reload register = 0, auto = 0.
  - tc = 0, busy = 0, load_ready = 1.
- States are IDLE, RUN and DONE.
  - load_ready = (state != RUN).
  - busy = (state == RUN).
- Load accept means load_valid && load_ready at a rising edge. On accept:
  - load_value is captured into both count and the reload register.
  - load_auto is captured into auto.
  - Next state:
    - RUN if load_value != 0.
    - If load_value == 0: count = 0, tc = 1 next cycle, state → DONE. Applies in both modes; no infinite zero-period loop.
- Priority per cycle: abort > load accept > en decrement.
- abort in any state:
  - Next edge: state → IDLE, count = 0, tc = 0.
  - Any simultaneous load is dropped.
- RUN with en = 0: count and state hold; tc = 0.
- RUN with en = 1 and count > 1: count decrements by 1.
- RUN with en = 1 and count == 1:
  - tc = 1 on the next cycle.
  - If auto = 1: count ← reload register and state stays RUN. The period is the reload value in enabled cycles.
  - If auto = 0: count ← 0 and state → DONE.
- Latency: tc asserts in the same cycle count is first observed at 0 (one-shot) or at the reload value (auto). From a load of N with en held high, tc appears exactly N cycles after the accept edge.
- DONE:
  - count holds at 0; en is ignored.
  - A load accept restarts per the load rules.
  - abort → IDLE.
- Arithmetic is unsigned modulo 2^WIDTH, but count never underflows: the 1→0 transition is the only path to 0, so no wrap below 0. Load of all-ones (15 at WIDTH = 4) is legal.
- Reset asserted mid-RUN clears everything immediately (asynchronously) with no tc pulse. After reset deasserts, the block is in IDLE.
- tc is a single-cycle pulse; it never stays high on consecutive cycles except in auto mode with reload value 1 and en held high.

Decomposition:
- Package down_timer_pkg:
  - typedef enum logic [1:0] timer_state_t {IDLE, RUN, DONE}.
  - localparam constants for mode encoding: MODE_ONESHOT = 0, MODE_AUTO = 1.
- One sub-module is natural: down_count_core, the WIDTH-bit register with load, decrement enable and is_one flag.
- The FSM, handshake and tc generation stay in down_count_timer.

Test Plan:
- Reset then one-shot: load 5 with auto = 0, en = 1 → count sequence 5, 4, 3, 2, 1, 0; tc high only in the cycle count becomes 0; state DONE; busy falls with tc; load_ready = 1 from that cycle.
- Auto-reload: load 3 with auto = 1, en = 1, run 10 cycles → count 3, 2, 1, 3, 2, 1, 3, …; tc every 3rd cycle; busy stays 1; load_ready stays 0.
- Enable gating: load 4, en toggles 1, 0, 0, 1, 1, 1 → count 4, 3, 3, 3, 2, 1, 0; tc exactly once, coinciding with 0.
- Boundaries:
  - Load 0 → count 0, tc pulse next cycle, state DONE.
  - Load 15 (all-ones) → 15 decrements to 0 with no wrap.
  - Auto mode with reload 1 → tc high every enabled cycle.
- Simultaneous events:
  - abort and load_valid in the same cycle → IDLE, count 0, load dropped.
  - Load during RUN → load_ready = 0, no capture, count unaffected.
  - Load in DONE → restarts RUN.
- Asynchronous reset mid-count: load 9, assert rst = 0 between clock edges at count 6 → count = 0, busy = 0 immediately with no tc; after deassert, count stays 0 until the next load.
